execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Stage 3 of the 16-bit in-order pipeline. Sits directly downstream of the decode stage and consumes its IR, PC and three operand words.
- Performs the ALU operation, resolves BEQ/JUMP, and produces the write-back, memory-request and branch-redirect signals.
- All outputs are registered: one-cycle latency. A 2-deep squash counter discards the wrong-path instructions already in fetch and decode after a taken redirect.

Parameters:
- SQUASH_DEPTH, 2: number of accepted slots discarded after a taken branch or jump.
- W, 16: datapath width.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- STAGE3IN  in  1  slot valid/enable from decode. When 0, the slot is a bubble.
- IRIN  in  16  instruction. Fields come from the shared definitions header: op[15:12], reg1[11:8], reg2[7:4], reg3[3:0], im[7:0], offset[3:0], target[7:0].
- PCIN  in  16  PC of the instruction.
- DATAIN1  in  16  operand 1, packed per opcode. R-type: destination index in [3:0]. ADDI/LW: destination index. SW: store value. BEQ: rs value. JUMP: target.
- DATAIN2  in  16  operand 2. R-type: A value. ADDI/SW/LW: im. BEQ: rt value.
- DATAIN3  in  16  operand 3. R-type: B value. BEQ: offset.
- IROUT  out  16  registered IR; 0 for bubble or squash.
- PCOUT  out  16  registered PC; 0 for bubble or squash.
- RESULT  out  16  ALU result, or memory address for LW/SW.
- STOREDATA  out  16  SW data.
- WREG  out  4  destination register.
- WEN  out  1  ALU/ADDI register write.
- MEMREAD  out  1  LW request.
- MEMWRITE  out  1  SW request.
- BRANCH  out  1  one-cycle redirect pulse.
- BRTARGET  out  16  redirect PC. Valid while BRANCH=1, otherwise 0.
- VALIDOUT  out  1  slot carries a real instruction.

Behaviour:
- Reset (RST=1, asynchronous): every output is 0, the squash counter is 0, and the forward registers are cleared. Reset in the middle of a squash cancels the squash.
- Each posedge CLK, the slot is live if STAGE3IN=1 and the squash counter is 0. A non-live slot registers all outputs to 0, including BRANCH and VALIDOUT.
- ADD, OR, AND: RESULT = A op B. SUB: RESULT = A - B, wrapping mod 2^16. WREG = DATAIN1[3:0]. WEN = 1.
- SLT: RESULT = 1 if signed A < signed B, else 0.
- ADDI: RESULT = {8'b0, DATAIN2[7:0]}. WREG = DATAIN1[3:0]. WEN = 1.
- LW: RESULT = {8'b0, DATAIN2[7:0]}. WREG = DATAIN1[3:0]. MEMREAD = 1. WEN = 0.
- SW: RESULT = {8'b0, DATAIN2[7:0]}. STOREDATA = DATAIN1. MEMWRITE = 1.
- BEQ: taken if DATAIN1 == DATAIN2. BRTARGET = PCIN + 1 + sign-extend(DATAIN3[3:0]).
- JUMP: always taken. BRTARGET = {8'b0, DATAIN1[7:0]}.
- Taken BEQ or JUMP: BRANCH = 1 for exactly one cycle and the squash counter loads SQUASH_DEPTH.
- Squash counter: decrements on each cycle with STAGE3IN=1 while it is nonzero. Bubbles do not consume squash slots. A taken branch arriving in a squashed slot is ignored.
- Undefined opcode: treated as NOP. VALIDOUT = 1, all other controls 0.
- VALIDOUT = 1 for every live slot.

Optional Feature:
- Macro: EXEC_FORWARD_EN.
- With the macro, the stage keeps the previous live slot's WREG/RESULT when that slot had WEN=1.
  - R-type: if the incoming reg2 equals the kept WREG, A is replaced by the kept RESULT. If reg3 equals the kept WREG, B is replaced the same way.
  - BEQ: the same substitution applies to reg1 and reg2.
  - LW destinations are never forwarded.
  - Bubbles and squashed slots do not update the kept values, and do not clear them.
- Without the macro: the DATAIN values are always used unmodified.

Test Plan:
- RST pulse mid-cycle with no CLK edge -> all outputs 0 immediately. Then ADD r1,r2,r3 with A=5, B=7 -> next edge RESULT=12, WREG=1, WEN=1, VALIDOUT=1.
- SUB with A=0, B=1 -> RESULT=16'hFFFF. SLT with A=16'hFFFF, B=1 -> RESULT=1.
- BEQ at PC=16'h0010, DATAIN1=DATAIN2=3, offset=4'hE -> BRANCH=1, BRTARGET=16'h000F.
  - Next two live ADDs are squashed (VALIDOUT=0, WEN=0).
  - The third ADD executes.
  - A bubble inserted between them does not shorten the squash.
- JUMP target 8'h40, immediately followed by a squashed JUMP 8'h80 -> exactly one BRANCH pulse, with BRTARGET=16'h0040.
- SW with DATAIN1=16'hBEEF, im=8'h22 -> MEMWRITE=1, RESULT=16'h0022, STOREDATA=16'hBEEF. LW with im=8'h05 to r4 -> MEMREAD=1, WREG=4, WEN=0.
- EXEC_FORWARD_EN defined:
  - ADDI r2,9 then ADD r1,r2,r3 with stale A=0 and B=1 -> RESULT=10.
  - Undefined -> RESULT=1.
  - LW r2 followed by the same ADD -> no forwarding.

Source files
------------

// File: rtl/execute_stage.sv
// Pipeline stage 3: ALU, BEQ/JUMP resolution and the wrong-path squash counter; all outputs registered (1 cycle).
// Optional operand forwarding from the previous live write-back slot is enabled with `define EXEC_FORWARD_EN.
module execute_stage #(
  parameter int SQUASH_DEPTH = 2,
  parameter int W            = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         STAGE3IN,
  input  logic [W-1:0] IRIN,
  input  logic [W-1:0] PCIN,
  input  logic [W-1:0] DATAIN1,
  input  logic [W-1:0] DATAIN2,
  input  logic [W-1:0] DATAIN3,
  output logic [W-1:0] IROUT,
  output logic [W-1:0] PCOUT,
  output logic [W-1:0] RESULT,
  output logic [W-1:0] STOREDATA,
  output logic [3:0]   WREG,
  output logic         WEN,
  output logic         MEMREAD,
  output logic         MEMWRITE,
  output logic         BRANCH,
  output logic [W-1:0] BRTARGET,
  output logic         VALIDOUT
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JUMP = 4'h9;

  localparam int SQW = (SQUASH_DEPTH < 1) ? 1 : $clog2(SQUASH_DEPTH + 1);

  logic [SQW-1:0] squash;
  logic           live;
  logic [3:0]     op;
  logic [W-1:0]   opa, opb, rs, rt;

  logic [W-1:0] n_result, n_storedata, n_brtarget;
  logic [3:0]   n_wreg;
  logic         n_wen, n_memread, n_memwrite, n_branch;

  logic unused_bits;
  assign unused_bits = ^{DATAIN3[W-1:4], IRIN[11:0]};

  assign op   = IRIN[15:12];
  assign live = STAGE3IN && (squash == '0);

`ifdef EXEC_FORWARD_EN
  logic [3:0]   fwd_reg;
  logic [W-1:0] fwd_result;
  logic         fwd_vld;

  // Only the immediately preceding live slot is remembered; a live slot without WEN drops it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fwd_reg    <= '0;
      fwd_result <= '0;
      fwd_vld    <= 1'b0;
    end else if (live) begin
      fwd_reg    <= n_wreg;
      fwd_result <= n_result;
      fwd_vld    <= n_wen;
    end
  end

  always_comb begin
    opa = DATAIN2;
    opb = DATAIN3;
    rs  = DATAIN1;
    rt  = DATAIN2;
    if (fwd_vld && IRIN[7:4] == fwd_reg) begin
      opa = fwd_result;
      rt  = fwd_result;
    end
    if (fwd_vld && IRIN[3:0] == fwd_reg) opb = fwd_result;
    if (fwd_vld && IRIN[11:8] == fwd_reg) rs = fwd_result;
  end
`else
  always_comb begin
    opa = DATAIN2;
    opb = DATAIN3;
    rs  = DATAIN1;
    rt  = DATAIN2;
  end
`endif

  always_comb begin
    n_result    = '0;
    n_storedata = '0;
    n_brtarget  = '0;
    n_wreg      = '0;
    n_wen       = 1'b0;
    n_memread   = 1'b0;
    n_memwrite  = 1'b0;
    n_branch    = 1'b0;
    if (live) begin
      unique case (op)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
          n_wreg = DATAIN1[3:0];
          n_wen  = 1'b1;
          case (op)
            OP_ADD:  n_result = opa + opb;
            OP_SUB:  n_result = opa - opb;
            OP_AND:  n_result = opa & opb;
            OP_OR:   n_result = opa | opb;
            default: n_result = ($signed(opa) < $signed(opb)) ? W'(1) : '0;
          endcase
        end
        OP_ADDI: begin
          n_result = {{(W-8){1'b0}}, DATAIN2[7:0]};
          n_wreg   = DATAIN1[3:0];
          n_wen    = 1'b1;
        end
        OP_LW: begin
          n_result  = {{(W-8){1'b0}}, DATAIN2[7:0]};
          n_wreg    = DATAIN1[3:0];
          n_memread = 1'b1;
        end
        OP_SW: begin
          n_result    = {{(W-8){1'b0}}, DATAIN2[7:0]};
          n_storedata = DATAIN1;
          n_memwrite  = 1'b1;
        end
        OP_BEQ: begin
          if (rs == rt) begin
            n_branch   = 1'b1;
            n_brtarget = PCIN + W'(1) + {{(W-4){DATAIN3[3]}}, DATAIN3[3:0]};
          end
        end
        OP_JUMP: begin
          n_branch   = 1'b1;
          n_brtarget = {{(W-8){1'b0}}, DATAIN1[7:0]};
        end
        default: ;
      endcase
    end
  end

  // Bubbles leave the squash count alone so only real wrong-path slots are consumed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      squash <= '0;
    end else if (STAGE3IN && squash != '0) begin
      squash <= squash - SQW'(1);
    end else if (n_branch) begin
      squash <= SQW'(SQUASH_DEPTH);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      IROUT     <= '0;
      PCOUT     <= '0;
      RESULT    <= '0;
      STOREDATA <= '0;
      WREG      <= '0;
      WEN       <= 1'b0;
      MEMREAD   <= 1'b0;
      MEMWRITE  <= 1'b0;
      BRANCH    <= 1'b0;
      BRTARGET  <= '0;
      VALIDOUT  <= 1'b0;
    end else begin
      IROUT     <= live ? IRIN : '0;
      PCOUT     <= live ? PCIN : '0;
      RESULT    <= n_result;
      STOREDATA <= n_storedata;
      WREG      <= n_wreg;
      WEN       <= n_wen;
      MEMREAD   <= n_memread;
      MEMWRITE  <= n_memwrite;
      BRANCH    <= n_branch;
      BRTARGET  <= n_brtarget;
      VALIDOUT  <= live;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage; forwarding expectations follow EXEC_FORWARD_EN.
module tb_execute_stage;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JUMP = 4'h9;
  localparam logic [3:0] OP_UND  = 4'hF;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        STAGE3IN = 1'b0;
  logic [15:0] IRIN = '0, PCIN = '0, DATAIN1 = '0, DATAIN2 = '0, DATAIN3 = '0;
  logic [15:0] IROUT, PCOUT, RESULT, STOREDATA, BRTARGET;
  logic [3:0]  WREG;
  logic        WEN, MEMREAD, MEMWRITE, BRANCH, VALIDOUT;

  int n_cmp = 0;
  int n_bad = 0;

  execute_stage #(.SQUASH_DEPTH(2), .W(16)) dut (
    .CLK(CLK), .RST(RST), .STAGE3IN(STAGE3IN), .IRIN(IRIN), .PCIN(PCIN),
    .DATAIN1(DATAIN1), .DATAIN2(DATAIN2), .DATAIN3(DATAIN3),
    .IROUT(IROUT), .PCOUT(PCOUT), .RESULT(RESULT), .STOREDATA(STOREDATA),
    .WREG(WREG), .WEN(WEN), .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE),
    .BRANCH(BRANCH), .BRTARGET(BRTARGET), .VALIDOUT(VALIDOUT)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk_ir(input logic [3:0] op, input logic [3:0] r1,
                                        input logic [3:0] r2, input logic [3:0] r3);
    return {op, r1, r2, r3};
  endfunction

  // Present one slot, clock it, and leave time at edge+1 for sampling.
  task automatic issue(input logic vld, input logic [15:0] ir, input logic [15:0] pc,
                       input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3);
    STAGE3IN = vld; IRIN = ir; PCIN = pc; DATAIN1 = d1; DATAIN2 = d2; DATAIN3 = d3;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_result"}, RESULT, 16'h0);
    check_eq({tag, "_ctl"}, {9'b0, VALIDOUT, WEN, MEMREAD, MEMWRITE, BRANCH, 2'b0}, 16'h0);
    check_eq({tag, "_irout"}, IROUT, 16'h0);
    check_eq({tag, "_brtarget"}, BRTARGET, 16'h0);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    check_all_zero("post_reset");

    // Make outputs nonzero, then reset between edges.
    issue(1, mk_ir(OP_ADD, 1, 2, 3), 16'h0005, 16'h0001, 16'h0005, 16'h0007);
    check_eq("pre_rst_valid", {15'b0, VALIDOUT}, 16'h1);
    #2 RST = 1'b1;
    #1 check_all_zero("async_rst");
    RST = 1'b0;

    issue(1, mk_ir(OP_ADD, 1, 2, 3), 16'h0005, 16'h0001, 16'h0005, 16'h0007);
    check_eq("add_result", RESULT, 16'd12);
    check_eq("add_wreg", {12'b0, WREG}, 16'd1);
    check_eq("add_wen_valid", {14'b0, WEN, VALIDOUT}, 16'b11);
    check_eq("add_irout", IROUT, 16'h0123);
    check_eq("add_pcout", PCOUT, 16'h0005);

    issue(1, mk_ir(OP_SUB, 5, 6, 7), 16'h0006, 16'h0005, 16'h0000, 16'h0001);
    check_eq("sub_wrap", RESULT, 16'hFFFF);
    issue(1, mk_ir(OP_SLT, 6, 7, 8), 16'h0007, 16'h0006, 16'hFFFF, 16'h0001);
    check_eq("slt_signed", RESULT, 16'h0001);
    issue(1, mk_ir(OP_AND, 7, 8, 9), 16'h0008, 16'h0007, 16'hF0F0, 16'hFF00);
    check_eq("and_result", RESULT, 16'hF000);
    issue(1, mk_ir(OP_OR, 8, 9, 10), 16'h0009, 16'h0008, 16'hF0F0, 16'h0F00);
    check_eq("or_result", RESULT, 16'hFFF0);

    issue(1, mk_ir(OP_BEQ, 10, 11, 14), 16'h0010, 16'h0003, 16'h0003, 16'h000E);
    check_eq("beq_branch", {15'b0, BRANCH}, 16'h1);
    check_eq("beq_target", BRTARGET, 16'h000F);
    check_eq("beq_wen", {15'b0, WEN}, 16'h0);
    issue(1, mk_ir(OP_ADD, 1, 2, 3), 16'h0011, 16'h0001, 16'h0001, 16'h0001);
    check_all_zero("squash1");
    issue(0, mk_ir(OP_ADD, 1, 2, 3), 16'h0012, 16'h0001, 16'h0001, 16'h0001);
    check_all_zero("bubble_in_squash");
    issue(1, mk_ir(OP_ADD, 1, 2, 3), 16'h0012, 16'h0001, 16'h0001, 16'h0001);
    check_all_zero("squash2");
    issue(1, mk_ir(OP_ADD, 2, 12, 13), 16'h000F, 16'h0002, 16'h0001, 16'h0002);
    check_eq("post_squash_valid", {15'b0, VALIDOUT}, 16'h1);
    check_eq("post_squash_result", RESULT, 16'h0003);

    issue(1, mk_ir(OP_JUMP, 0, 4, 0), 16'h0010, 16'h0040, 16'h0000, 16'h0000);
    check_eq("jump_branch", {15'b0, BRANCH}, 16'h1);
    check_eq("jump_target", BRTARGET, 16'h0040);
    issue(1, mk_ir(OP_JUMP, 0, 8, 0), 16'h0011, 16'h0080, 16'h0000, 16'h0000);
    check_eq("jump2_no_pulse", {15'b0, BRANCH}, 16'h0);
    check_eq("jump2_target", BRTARGET, 16'h0000);
    issue(1, mk_ir(OP_ADD, 1, 2, 3), 16'h0012, 16'h0001, 16'h0001, 16'h0001);
    check_all_zero("jump_squash2");

    issue(1, mk_ir(OP_SW, 0, 2, 2), 16'h0040, 16'hBEEF, 16'h0022, 16'h0000);
    check_eq("sw_memwrite", {15'b0, MEMWRITE}, 16'h1);
    check_eq("sw_addr", RESULT, 16'h0022);
    check_eq("sw_data", STOREDATA, 16'hBEEF);
    check_eq("sw_wen", {15'b0, WEN}, 16'h0);
    issue(1, mk_ir(OP_LW, 4, 0, 5), 16'h0041, 16'h0004, 16'h0005, 16'h0000);
    check_eq("lw_memread", {15'b0, MEMREAD}, 16'h1);
    check_eq("lw_wreg", {12'b0, WREG}, 16'h0004);
    check_eq("lw_wen", {15'b0, WEN}, 16'h0);
    check_eq("lw_addr", RESULT, 16'h0005);
    check_eq("lw_storedata", STOREDATA, 16'h0000);

    issue(1, mk_ir(OP_UND, 1, 2, 3), 16'h0042, 16'h0001, 16'h0005, 16'h0007);
    check_eq("undef_ctl", {11'b0, VALIDOUT, WEN, MEMREAD, MEMWRITE, BRANCH}, 16'b10000);
    check_eq("undef_result", RESULT, 16'h0000);
    issue(1, mk_ir(OP_BEQ, 10, 11, 3), 16'h0043, 16'h0001, 16'h0002, 16'h0003);
    check_eq("beq_nt_branch", {15'b0, BRANCH}, 16'h0);
    check_eq("beq_nt_target", BRTARGET, 16'h0000);

    // Forwarding cases: ADDI r2,9 then ADD r1,r2,r3 with stale A=0, B=1.
    issue(1, mk_ir(OP_ADDI, 2, 0, 9), 16'h0050, 16'h0002, 16'h0009, 16'h0000);
    check_eq("addi_result", RESULT, 16'h0009);
    check_eq("addi_wen", {15'b0, WEN}, 16'h1);
    issue(1, mk_ir(OP_ADD, 1, 2, 3), 16'h0051, 16'h0001, 16'h0000, 16'h0001);
`ifdef EXEC_FORWARD_EN
    check_eq("fwd_addi_add", RESULT, 16'd10);
`else
    check_eq("nofwd_addi_add", RESULT, 16'd1);
`endif
    issue(1, mk_ir(OP_ADDI, 2, 0, 9), 16'h0052, 16'h0002, 16'h0009, 16'h0000);
    issue(0, mk_ir(OP_UND, 0, 0, 0), 16'h0053, 16'h0000, 16'h0000, 16'h0000);
    issue(1, mk_ir(OP_ADD, 1, 2, 3), 16'h0053, 16'h0001, 16'h0000, 16'h0001);
`ifdef EXEC_FORWARD_EN
    check_eq("fwd_across_bubble", RESULT, 16'd10);
`else
    check_eq("nofwd_across_bubble", RESULT, 16'd1);
`endif
    issue(1, mk_ir(OP_ADDI, 2, 0, 9), 16'h0054, 16'h0002, 16'h0009, 16'h0000);
    issue(1, mk_ir(OP_UND, 0, 0, 0), 16'h0055, 16'h0000, 16'h0000, 16'h0000);
    issue(1, mk_ir(OP_ADD, 1, 2, 3), 16'h0056, 16'h0001, 16'h0000, 16'h0001);
    check_eq("undef_breaks_fwd", RESULT, 16'd1);
    issue(1, mk_ir(OP_LW, 2, 0, 5), 16'h0057, 16'h0002, 16'h0005, 16'h0000);
    issue(1, mk_ir(OP_ADD, 1, 2, 3), 16'h0058, 16'h0001, 16'h0000, 16'h0001);
    check_eq("lw_not_fwd", RESULT, 16'd1);

    // Reset during a squash cancels it.
    issue(1, mk_ir(OP_JUMP, 0, 4, 0), 16'h0060, 16'h0040, 16'h0000, 16'h0000);
    check_eq("jump3_branch", {15'b0, BRANCH}, 16'h1);
    #2 RST = 1'b1;
    #1 check_eq("rst_clears_branch", {15'b0, BRANCH}, 16'h0);
    RST = 1'b0;
    issue(1, mk_ir(OP_ADD, 1, 2, 3), 16'h0061, 16'h0001, 16'h0005, 16'h0007);
    check_eq("rst_cancel_squash_valid", {15'b0, VALIDOUT}, 16'h1);
    check_eq("rst_cancel_squash_result", RESULT, 16'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
